// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and rr_arbiter8
interface rr_arbiter8_if;
    logic [0:7] req;
    logic [0:7] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    // Arbiter side: samples requests, drives the grant in decoded and encoded form.
    modport master (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

    modport slave (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-requester round-robin arbiter with hold-limit rotation
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter8_if.master bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbStateT;

    localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    arbStateT   state;
    arbStateT   nextState;
    logic [2:0] ptr;
    logic [7:0] hcnt;
    logic [0:7] gntQ;
    logic [2:0] gntIdxQ;
    logic       gntValidQ;

    logic [0:7] others;
    logic [0:7] cand;
    logic [2:0] winner;
    logic [2:0] scanIdx;
    logic       found;
    logic [0:7] winnerHot;
    logic       grantNew;
    logic       dropGrant;

    // Winner search starts at ptr and wraps 7 -> 0; in IDLE all requests compete,
    // in BUSY only the non-owners do.
    always_comb begin
        others          = bus.req;
        others[gntIdxQ] = 1'b0;
        cand            = (state == IDLE) ? bus.req : others;
        winner          = 3'd0;
        found           = 1'b0;
        scanIdx         = 3'd0;
        for (int k = 0; k < 8; k++) begin
            scanIdx = ptr + 3'(k);
            if (!found && cand[scanIdx]) begin
                winner = scanIdx;
                found  = 1'b1;
            end
        end
        winnerHot         = '0;
        winnerHot[winner] = 1'b1;
    end

    always_comb begin
        nextState = state;
        grantNew  = 1'b0;
        dropGrant = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    grantNew  = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                if (!bus.req[gntIdxQ]) begin
                    if (|others) begin
                        grantNew = 1'b1;
                    end else begin
                        dropGrant = 1'b1;
                        nextState = IDLE;
                    end
                end else if (PREEMPT_EN && (hcnt >= HOLD_LAST) && (|others)) begin
                    grantNew = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hcnt      <= 8'd0;
            gntQ      <= '0;
            gntIdxQ   <= 3'd0;
            gntValidQ <= 1'b0;
        end else begin
            state <= nextState;
            if (grantNew) begin
                gntQ      <= winnerHot;
                gntIdxQ   <= winner;
                gntValidQ <= 1'b1;
                hcnt      <= 8'd0;
                ptr       <= winner + 3'd1;
            end else if (dropGrant) begin
                gntQ      <= '0;
                gntIdxQ   <= 3'd0;
                gntValidQ <= 1'b0;
                hcnt      <= 8'd0;
            end else if (state == BUSY && hcnt != 8'hFF) begin
                hcnt <= hcnt + 8'd1;
            end
        end
    end

    assign bus.gnt       = gntQ;
    assign bus.gnt_idx   = gntIdxQ;
    assign bus.gnt_valid = gntValidQ;
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares a single resource between requesters 0–7 and drives the grant in both forms used by our decoder/encoder datapath. It outputs a one-hot grant vector in decoded Y0..Y7 order and the matching 3-bit encoded index X2X1X0. Each grant is held while its requester keeps asking. A hold limit forces rotation when other requesters are waiting. The block sits ahead of the shared resource and steers its select lines.

## Interface
- MAX_HOLD, default 4: maximum consecutive grant cycles for one owner while any other request is pending. Range 0..255; 0 = never preempt.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  [0:7]  request vector; req[i] = requester i (Y-order, bit 0 leftmost).
- gnt  output  [0:7]  one-hot grant, same ordering as req; all zero when no grant.
- gnt_idx  output  [2:0]  encoded index of current owner; 0 when no grant.
- gnt_valid  output  1  high while a grant is active.

## Operation
- All outputs are registered.
- Internal state:
  - FSM state IDLE/BUSY.
  - 3-bit round-robin pointer ptr.
  - 8-bit hold counter hcnt.
- Winner selection: first set bit of the candidate set, scanning ptr, ptr+1, … mod 8, wrapping 7→0.
- On every new grant to requester w:
  - gnt := one-hot(w), gnt_idx := w, gnt_valid := 1.
  - hcnt := 0.
  - ptr := (w+1) mod 8.
- IDLE:
  - req == 0 → stay IDLE, outputs zero.
  - Otherwise grant the winner over req → BUSY.
- BUSY, owner o = gnt_idx, others = req with bit o masked:
  - req[o] == 0, others != 0 → grant winner over others at the same edge (no idle cycle), stay BUSY.
  - req[o] == 0, others == 0 → IDLE; gnt, gnt_idx, gnt_valid clear at that edge.
  - req[o] == 1, MAX_HOLD != 0, hcnt == MAX_HOLD-1, others != 0 → preempt: grant winner over others.
  - req[o] == 1, otherwise → keep grant; hcnt increments, saturating at 255.
- Uncontended owner holds indefinitely. hcnt keeps counting; preemption triggers at the first edge where others != 0 and hcnt ≥ MAX_HOLD-1.
- Invariants:
  - gnt_valid == |gnt.
  - gnt == decode3to8(gnt_idx) when valid.
  - gnt is never multi-hot.
  - gnt_idx == encode8to3(gnt).
- Reset:
  - Dominates all other inputs.
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, state IDLE, ptr = 0, hcnt = 0.
  - Reset mid-grant drops the grant at that edge; no grant is remembered across reset.

## Timing
- Request-to-grant latency: 1 cycle. req sampled at edge N → gnt visible after edge N.
- Release-to-drop latency: 1 cycle. Owner deasserts req before edge N → gnt changes at edge N.
- Handoff between owners is gapless: old grant and new grant on consecutive cycles, never both.
- Under continuous contention each owner sees gnt_valid for exactly MAX_HOLD cycles.
- A requester that deasserts before being granted is simply skipped; there is no queueing.
- Simultaneous owner release and new requests at the same edge: the new requests participate in that edge's selection.
- Reset asserted with req != 0: no grant during reset. First grant appears 1 cycle after reset deasserts, selected from ptr = 0.

## Test plan
- Reset: reset=1 for 2 cycles with req=8'b11111111 → gnt=0, gnt_idx=000, gnt_valid=0 throughout. One cycle after reset falls, gnt=10000000, gnt_idx=000.
- Single holder, MAX_HOLD=4: req[5] high for 10 cycles, others 0 → gnt=00000100, gnt_idx=101 from cycle 1 through cycle 10 (no preemption). All outputs 0 one cycle after req[5] falls.
- Full contention, MAX_HOLD=4: req=11111111 held 40 cycles → gnt_idx sequence 0,1,2,…,7,0, each exactly 4 cycles, no gnt_valid gaps, gnt always decode(gnt_idx).
- Release handoff with wrap: owner 3 active, req[6] and req[1] pending.
  - req[3] drops → next edge gnt_idx=110.
  - req[6] then drops → next edge gnt_idx=001 (wrap 7→0→1).
- Reset mid-grant: owner 2 active with req={2,4} high, reset pulse 1 cycle → outputs clear at that edge. After release, gnt_idx=010 (ptr reset to 0, so 2 wins over 4).
- MAX_HOLD=0: req[0] and req[7] both high 20 cycles → gnt_idx=000 for all 20 cycles. Grant moves to 111 one cycle after req[0] falls.
